// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB PWM path: hue sector encoding, channel
// count and duty-word width.
package rgb_pkg;

  localparam int unsigned NUM_CH = 3;

  typedef enum logic [2:0] {
    PH_RG_UP = 3'd0,
    PH_R_DN  = 3'd1,
    PH_B_UP  = 3'd2,
    PH_G_DN  = 3'd3,
    PH_R_UP  = 3'd4,
    PH_B_DN  = 3'd5
  } phase_t;

  function automatic int unsigned dw(input int unsigned pwm_interval);
    return $clog2(pwm_interval + 1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clk cycles by DIV and emits a combinational tick on the last
// count; the count holds whenever en is low.
module tick_prescaler #(
  parameter int unsigned DIV = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_chk_div
    $error("tick_prescaler: DIV must be at least 1");
  end

  logic [PW-1:0] r_pc;

  assign tick = en && (r_pc == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
    end else if (tick) begin
      r_pc <= '0;
    end else if (en) begin
      r_pc <= r_pc + PW'(1);
    end
  end

endmodule

// File: rtl/hue_wheel_sequencer.sv
// Steps around the six-sector HSV hue wheel and registers red/green/blue duty
// words for the downstream PWM generator.
module hue_wheel_sequencer
  import rgb_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL    = 1800,
  parameter int unsigned MAX_PHASES      = 6,
  parameter int unsigned STEPS_PER_PHASE = 100,
  parameter int unsigned UPDATE_DIV      = 20000,
  localparam int unsigned DW             = dw(PWM_INTERVAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic [2:0]    phase,
  output logic          update,
  output logic          wrap
);

  localparam int unsigned DUTY_STEP = PWM_INTERVAL / STEPS_PER_PHASE;
  localparam int unsigned SW        = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS_PER_PHASE - 1);
  localparam logic [DW-1:0] FULL      = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] ZERO      = '0;

  if (MAX_PHASES != 6) begin : g_chk_phases
    $error("hue_wheel_sequencer: MAX_PHASES must be 6");
  end
  if (PWM_INTERVAL % STEPS_PER_PHASE != 0) begin : g_chk_steps
    $error("hue_wheel_sequencer: PWM_INTERVAL must be a multiple of STEPS_PER_PHASE");
  end

  logic w_tick;

  tick_prescaler #(
    .DIV (UPDATE_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (w_tick)
  );

  logic [SW-1:0] r_step;
  phase_t        r_phase;
  logic          r_stepped;
  logic          r_wrapped;

  // r_stepped/r_wrapped delay the tick so the pulses line up with the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step    <= '0;
      r_phase   <= PH_RG_UP;
      r_stepped <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_stepped <= w_tick;
      r_wrapped <= w_tick && (r_step == LAST_STEP) && (r_phase == PH_B_DN);
      if (w_tick) begin
        if (r_step == LAST_STEP) begin
          r_step  <= '0;
          r_phase <= (r_phase == PH_B_DN) ? PH_RG_UP : phase_t'(r_phase + 3'd1);
        end else begin
          r_step <= r_step + SW'(1);
        end
      end
    end
  end

  logic [DW-1:0]             w_up;
  logic [DW-1:0]             w_dn;
  logic [NUM_CH-1:0][DW-1:0] w_map;  // [2]=red, [1]=green, [0]=blue

  assign w_up = DW'(r_step) * DW'(DUTY_STEP);
  assign w_dn = FULL - w_up;

  always_comb begin
    w_map = {FULL, ZERO, ZERO};
    unique case (r_phase)
      PH_RG_UP: w_map = {FULL, w_up, ZERO};
      PH_R_DN:  w_map = {w_dn, FULL, ZERO};
      PH_B_UP:  w_map = {ZERO, FULL, w_up};
      PH_G_DN:  w_map = {ZERO, w_dn, FULL};
      PH_R_UP:  w_map = {w_up, ZERO, FULL};
      PH_B_DN:  w_map = {FULL, ZERO, w_dn};
      default:  w_map = {FULL, ZERO, ZERO};
    endcase
  end

  logic [NUM_CH-1:0][DW-1:0] r_duty;
  phase_t                    r_phase_out;
  logic                      r_update;
  logic                      r_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty      <= {FULL, ZERO, ZERO};
      r_phase_out <= PH_RG_UP;
      r_update    <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_duty      <= w_map;
      r_phase_out <= r_phase;
      r_update    <= r_stepped;
      r_wrap      <= r_wrapped;
    end
  end

  assign duty_r = r_duty[2];
  assign duty_g = r_duty[1];
  assign duty_b = r_duty[0];
  assign phase  = r_phase_out;
  assign update = r_update;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_hue_wheel_sequencer.sv
// Randomised scoreboard bench for hue_wheel_sequencer, with a second instance
// built with UPDATE_DIV=1 checked in lockstep.
module tb_hue_wheel_sequencer;

  localparam int M     = 12;
  localparam int S     = 4;
  localparam int DIV   = 3;
  localparam int D     = M / S;
  localparam int DW    = 4;
  localparam int WHEEL = 6 * S;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic rst1 = 1'b1;
  logic en1 = 1'b0;
  logic [DW-1:0] duty_r, duty_g, duty_b, d1_r, d1_g, d1_b;
  logic [2:0] phase, phase1;
  logic update, wrap, update1, wrap1;

  hue_wheel_sequencer #(
    .PWM_INTERVAL    (M),
    .MAX_PHASES      (6),
    .STEPS_PER_PHASE (S),
    .UPDATE_DIV      (DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .duty_r (duty_r),
    .duty_g (duty_g),
    .duty_b (duty_b),
    .phase  (phase),
    .update (update),
    .wrap   (wrap)
  );

  hue_wheel_sequencer #(
    .PWM_INTERVAL    (M),
    .MAX_PHASES      (6),
    .STEPS_PER_PHASE (S),
    .UPDATE_DIV      (1)
  ) dut1 (
    .clk    (clk),
    .rst    (rst1),
    .en     (en1),
    .duty_r (d1_r),
    .duty_g (d1_g),
    .duty_b (d1_b),
    .phase  (phase1),
    .update (update1),
    .wrap   (wrap1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int g;
    int b;
    int ph;
    int wr;
    int due;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int m_en_cnt = 0;
  int m_ticks = 0;
  int hold_r = M;
  int hold_g = 0;
  int hold_b = 0;
  int hold_ph = 0;

  // HSV channel value with V=S=1: n is 5/3/1 for red/green/blue, h is hue in steps.
  function automatic int chan(input int n, input int h);
    int k, t;
    k = (n * S + h) % WHEEL;
    t = k;
    if (4 * S - k < t) t = 4 * S - k;
    if (S < t) t = S;
    if (t < 0) t = 0;
    return M - t * D;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: every DIV-th enabled cycle is a step; hue = step count mod wheel.
  initial begin : model
    exp_t e;
    int h;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_en_cnt = 0;
        m_ticks  = 0;
        sb_q.delete();
        hold_r  = M;
        hold_g  = 0;
        hold_b  = 0;
        hold_ph = 0;
      end else if (en) begin
        m_en_cnt++;
        if (m_en_cnt % DIV == 0) begin
          m_ticks++;
          h     = m_ticks % WHEEL;
          e.r   = chan(5, h);
          e.g   = chan(3, h);
          e.b   = chan(1, h);
          e.ph  = h / S;
          e.wr  = (h == 0) ? 1 : 0;
          e.due = cyc + 1;
          sb_q.push_back(e);
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int mx, mn, mid;
    forever begin
      @(negedge clk);
      if (update) begin
        if (sb_q.size() == 0) begin
          check("spurious_update", int'(update), 0);
        end else begin
          e = sb_q.pop_front();
          check("update_cycle", cyc, e.due);
          check("duty_r", int'(duty_r), e.r);
          check("duty_g", int'(duty_g), e.g);
          check("duty_b", int'(duty_b), e.b);
          check("phase", int'(phase), e.ph);
          check("wrap", int'(wrap), e.wr);
          hold_r  = e.r;
          hold_g  = e.g;
          hold_b  = e.b;
          hold_ph = e.ph;
        end
      end else begin
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
          check("missing_update", int'(update), 1);
          e = sb_q.pop_front();
          hold_r  = e.r;
          hold_g  = e.g;
          hold_b  = e.b;
          hold_ph = e.ph;
        end else begin
          check("wrap_idle", int'(wrap), 0);
          check("hold_r", int'(duty_r), hold_r);
          check("hold_g", int'(duty_g), hold_g);
          check("hold_b", int'(duty_b), hold_b);
          check("hold_phase", int'(phase), hold_ph);
        end
      end
      mx  = int'(duty_r);
      mn  = int'(duty_r);
      if (int'(duty_g) > mx) mx = int'(duty_g);
      if (int'(duty_b) > mx) mx = int'(duty_b);
      if (int'(duty_g) < mn) mn = int'(duty_g);
      if (int'(duty_b) < mn) mn = int'(duty_b);
      mid = int'(duty_r) + int'(duty_g) + int'(duty_b) - mx - mn;
      check("invariant", (mx == M && mn == 0 && mid % D == 0) ? 1 : 0, 1);
    end
  end

  // UPDATE_DIV=1 instance: every enabled edge is a step, visible one edge later.
  initial begin : chk_div1
    int k1, exp_k, h;
    bit t_prev, exp_u;
    k1 = 0;
    exp_k = 0;
    t_prev = 1'b0;
    exp_u = 1'b0;
    forever begin
      @(posedge clk);
      if (rst1) begin
        exp_u  = 1'b0;
        k1     = 0;
        t_prev = 1'b0;
      end else begin
        exp_u  = t_prev;
        exp_k  = k1;
        t_prev = en1;
        if (en1) k1++;
      end
      @(negedge clk);
      h = exp_k % WHEEL;
      check("div1_update", int'(update1), int'(exp_u));
      check("div1_wrap", int'(wrap1), (exp_u && h == 0) ? 1 : 0);
      if (exp_u) begin
        check("div1_duty_r", int'(d1_r), chan(5, h));
        check("div1_duty_g", int'(d1_g), chan(3, h));
        check("div1_duty_b", int'(d1_b), chan(1, h));
        check("div1_phase", int'(phase1), h / S);
      end
    end
  end

  initial begin : stim_div1
    rst1 = 1'b1;
    en1  = 1'b0;
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    en1  = 1'b1;
    repeat (60) @(negedge clk);
    en1 = 1'b0;
    repeat (3) @(negedge clk);
    en1 = 1'b1;
    repeat (5) @(negedge clk);
    en1 = 1'b0;
  end

  initial begin : stim
    int rel;
    int waited;
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Release with en already high; first update after DIV+1 edges.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    rel = cyc;
    for (int i = 0; i < 10 && !update; i++) @(negedge clk);
    check("first_update_latency", cyc - rel, DIV + 1);
    repeat (WHEEL * DIV + 4) @(negedge clk);

    // Drop en while the prescaler sits on its last count.
    waited = 0;
    while (m_en_cnt % DIV != DIV - 1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (8) @(negedge clk);

    // Reset in the middle of the phase-3 ramp.
    waited = 0;
    while (!((m_ticks % WHEEL) / S == 3 && m_ticks % S == 2) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    repeat (400) begin
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    en  = 1'b1;
    repeat (8) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
